// File: rtl/wimax_pkg.sv
// Shared constants and index type for the 802.16e QPSK block deinterleaver.
package wimax_pkg;

  localparam int WIMAX_NCBPS = 192;
  localparam int WIMAX_D     = 16;
  localparam int WIMAX_ROWS  = WIMAX_NCBPS / WIMAX_D;

  typedef logic [$clog2(WIMAX_NCBPS)-1:0] bit_idx_t;

endpackage

// File: rtl/wimax_deinterleaver_if.sv
// Bit-serial stream bundle: demodulator-side input and FEC-side output of the deinterleaver.
interface wimax_deinterleaver_if;

  // Both streams use valid/ready: a bit moves on a rising clock edge where
  // valid & ready are both high; the source holds its bit stable while valid & ~ready.
  logic in_bit;
  logic in_valid;
  logic in_ready;
  logic out_bit;
  logic out_valid;
  logic out_ready;
  logic out_last;

  modport slave (
    input  in_bit,
    input  in_valid,
    output in_ready,
    output out_bit,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport master (
    output in_bit,
    output in_valid,
    input  in_ready,
    input  out_bit,
    input  out_valid,
    output out_ready,
    input  out_last
  );

endinterface

// File: rtl/wimax_deint_addr_gen.sv
// Write-address generator: walks k = D*(j mod ROWS) + floor(j/ROWS) with counters only.
module wimax_deint_addr_gen
  import wimax_pkg::*;
#(
  parameter int NCBPS = WIMAX_NCBPS,
  parameter int D     = WIMAX_D
) (
  input  logic                     clk,
  input  logic                     reset_N,
  input  logic                     step,
  output logic [$clog2(NCBPS)-1:0] k,
  output logic                     last
);

  localparam int ROWS = NCBPS / D;
  localparam int W    = $clog2(NCBPS);

  typedef logic [W-1:0] idx_t;

  localparam idx_t ROW_LAST = idx_t'(ROWS - 1);
  localparam idx_t COL_LAST = idx_t'(D - 1);
  localparam idx_t K_STEP   = idx_t'(D);
  localparam idx_t ONE      = idx_t'(1);

  idx_t row_q, row_d;
  idx_t col_q, col_d;
  idx_t kb_q, kb_d;
  logic row_end;

  always_comb begin
    row_end = (row_q == ROW_LAST);
    last    = row_end && (col_q == COL_LAST);
    k       = kb_q + col_q;
  end

  // row tracks j mod ROWS, col tracks floor(j/ROWS), kb_q tracks D*row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    kb_d  = kb_q;
    if (step) begin
      if (last) begin
        row_d = '0;
        col_d = '0;
        kb_d  = '0;
      end else if (row_end) begin
        row_d = '0;
        kb_d  = '0;
        col_d = col_q + ONE;
      end else begin
        row_d = row_q + ONE;
        kb_d  = kb_q + K_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      row_q <= '0;
      col_q <= '0;
      kb_q  <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
      kb_q  <= kb_d;
    end
  end

endmodule

// File: rtl/wimax_deinterleaver.sv
// Ping-pong block deinterleaver: one bank fills in permuted order while the other drains linearly.
module wimax_deinterleaver
  import wimax_pkg::*;
#(
  parameter int NCBPS = WIMAX_NCBPS,
  parameter int D     = WIMAX_D
) (
  input  logic                   clk,
  input  logic                   reset_N,
  wimax_deinterleaver_if.slave   bus
);

  localparam int W = $clog2(NCBPS);

  typedef logic [W-1:0] idx_t;

  localparam idx_t K_LAST = idx_t'(NCBPS - 1);
  localparam idx_t ONE    = idx_t'(1);

  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       full_q, full_d;
  idx_t             rd_k_q, rd_k_d;
  logic [NCBPS-1:0] mem_q [2];

  idx_t wr_k;
  logic wr_last;
  logic in_ready;
  logic out_valid;
  logic in_fire;
  logic out_fire;
  logic rd_last;

  wimax_deint_addr_gen #(
    .NCBPS (NCBPS),
    .D     (D)
  ) u_addr_gen (
    .clk     (clk),
    .reset_N (reset_N),
    .step    (in_fire),
    .k       (wr_k),
    .last    (wr_last)
  );

  always_comb begin
    in_ready  = ~full_q[wr_sel_q];
    out_valid = full_q[rd_sel_q];
    rd_last   = (rd_k_q == K_LAST);
    in_fire   = bus.in_valid & in_ready;
    out_fire  = out_valid & bus.out_ready;
  end

  // Writer only touches a non-full bank and reader only a full one, so the
  // two full-flag updates below can never collide on the same bank.
  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    rd_k_d   = rd_k_q;
    if (in_fire && wr_last) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end
    if (out_fire) begin
      if (rd_last) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        rd_k_d           = '0;
      end else begin
        rd_k_d = rd_k_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= '0;
      rd_k_q   <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      rd_k_q   <= rd_k_d;
    end
  end

  // Storage needs no reset: nothing is read until its full flag is set.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem_q[wr_sel_q][wr_k] <= bus.in_bit;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_valid & mem_q[rd_sel_q][rd_k_q];
  assign bus.out_last  = out_valid & rd_last;

endmodule

// File: tb/tb_wimax_deinterleaver.sv
// Self-checking bench for the block deinterleaver: scenario tasks plus a scoreboard monitor.
module tb_wimax_deinterleaver;
  import wimax_pkg::*;

  localparam int N    = WIMAX_NCBPS;
  localparam int D    = WIMAX_D;
  localparam int ROWS = WIMAX_ROWS;

  logic clk = 1'b0;
  logic reset_N;

  wimax_deinterleaver_if bus();

  wimax_deinterleaver dut (
    .clk     (clk),
    .reset_N (reset_N),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors       = 0;
  int checks       = 0;
  int ready_mode   = 0;
  int outputs_seen = 0;
  int in_stalls    = 0;
  logic [1:0] exp_q[$];

  // Transmit-side first permutation: coded bit k lands at position j.
  function automatic logic [N-1:0] interleave(input logic [N-1:0] v);
    logic [N-1:0] tx;
    tx = '0;
    for (int k = 0; k < N; k++) tx[ROWS * (k % D) + k / D] = v[k];
    return tx;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  task automatic push_bit(input logic b, input bit gaps);
    int w;
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_bit   = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 2000) begin
      in_stalls++;
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: in_ready=%0b after %0d cycles, need 1", bus.in_ready, w);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_block(input logic [N-1:0] v, input bit gaps, input int nbits);
    logic [N-1:0] tx;
    tx = interleave(v);
    if (nbits == N) begin
      for (int k = 0; k < N; k++) exp_q.push_back({k == N - 1, v[k]});
    end
    for (int j = 0; j < nbits; j++) push_bit(tx[j], gaps);
    bus.in_valid = 1'b0;
  endtask

  // Scoreboard, stall-stability checker and out_ready driver.
  task automatic monitor();
    logic [1:0] exp;
    logic prev_stall = 1'b0;
    logic prev_bit   = 1'b0;
    logic prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_N) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_bit !== prev_bit || bus.out_last !== prev_last) begin
            errors++;
            $display("FAIL stall_hold: valid/bit/last=%b%b%b, need 1%b%b",
                     bus.out_valid, bus.out_bit, bus.out_last, prev_bit, prev_last);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          checks++;
          outputs_seen++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: last/bit=%b%b with empty queue", bus.out_last, bus.out_bit);
          end else begin
            exp = exp_q.pop_front();
            if ({bus.out_last, bus.out_bit} !== exp) begin
              errors++;
              $display("FAIL scoreboard: last/bit=%b%b, need %b", bus.out_last, bus.out_bit, exp);
            end
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_bit   = bus.out_bit;
        prev_last  = bus.out_last;
      end
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d bits left, need 0", exp_q.size());
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_drain: out_valid=%b, need 0", bus.out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_N      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, need 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, need 0", bus.out_valid); end
    checks++;
    if (bus.out_bit !== 1'b0) begin errors++; $display("FAIL reset_out_bit: got %b, need 0", bus.out_bit); end
    checks++;
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, need 0", bus.out_last); end
    reset_N = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_one();
    ready_mode = 0;
    for (int k = 0; k < N; k++) exp_q.push_back({k == N - 1, k == 1});
    for (int j = 0; j < N; j++) push_bit(j == 12, 1'b0);
    bus.in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_random_blocks();
    ready_mode = 0;
    for (int b = 0; b < 50; b++) push_block(rand_vec(), 1'b0, N);
    wait_drain();
  endtask

  task automatic test_streaming();
    logic [N-1:0] vecs [4];
    int s0;
    int run;
    ready_mode = 0;
    for (int b = 0; b < 4; b++) vecs[b] = rand_vec();
    s0  = in_stalls;
    run = 0;
    fork
      begin
        for (int b = 0; b < 4; b++) push_block(vecs[b], 1'b0, N);
      end
      begin
        repeat (N - 1) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid: got %b, need 0", bus.out_valid); end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_first_valid: got %b, need 1", bus.out_valid); end
        for (int c = 0; c < 4 * N - 1; c++) begin
          @(negedge clk);
          if (bus.out_valid === 1'b1) run++;
        end
        checks++;
        if (run != 4 * N - 1) begin errors++; $display("FAIL stream_continuous: %0d valid cycles, need %0d", run + 1, 4 * N); end
      end
    join
    checks++;
    if (in_stalls != s0) begin errors++; $display("FAIL stream_in_ready: %0d stall cycles, need 0", in_stalls - s0); end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int s0;
    int reads;
    int w;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    s0 = in_stalls;
    push_block(rand_vec(), 1'b0, N);
    push_block(rand_vec(), 1'b0, N);
    checks++;
    if (in_stalls != s0) begin errors++; $display("FAIL bp_early_stall: %0d stall cycles, need 0", in_stalls - s0); end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b, need 0", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b, need 1", bus.out_valid); end
    @(posedge clk); #1;
    ready_mode = 0;
    reads = 0;
    w = 0;
    while (reads < N && w < 1000) begin
      @(negedge clk);
      w++;
      if (bus.out_valid && bus.out_ready) reads++;
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_at_last_read: got %b, need 0 (reads=%0d)", bus.in_ready, reads); end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_return: got %b, need 1", bus.in_ready); end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_random_handshake();
    int s0;
    ready_mode = 2;
    s0 = outputs_seen;
    for (int b = 0; b < 20; b++) push_block(rand_vec(), 1'b1, N);
    wait_drain();
    ready_mode = 0;
    checks++;
    if (outputs_seen - s0 != 20 * N) begin
      errors++;
      $display("FAIL random_count: %0d bits out, need %0d", outputs_seen - s0, 20 * N);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int s0;
    ready_mode = 0;
    push_block(rand_vec(), 1'b0, N);
    push_block(rand_vec(), 1'b0, 100);
    reset_N = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b, need 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b, need 0", bus.out_valid); end
    repeat (2) @(posedge clk);
    #1;
    reset_N = 1'b1;
    @(posedge clk); #1;
    s0 = outputs_seen;
    push_block(rand_vec(), 1'b0, N);
    wait_drain();
    checks++;
    if (outputs_seen - s0 != N) begin
      errors++;
      $display("FAIL midreset_count: %0d bits out, need %0d", outputs_seen - s0, N);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    reset_N       = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_one();
    test_random_blocks();
    test_streaming();
    test_backpressure();
    test_random_handshake();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
